// File: rtl/codificador_teclado_pkg.sv
// Shared FSM state type and priority-encode helper for the clocked keypad encoder.
package codificador_teclado_pkg;

    localparam int unsigned MAX_TECLAS = 64;

    typedef enum logic [1:0] {
        StOcioso,
        StFiltrando,
        StPressionado,
        StSoltando
    } estado_t;

    // Highest set index wins; an all-zero vector yields 0.
    function automatic int unsigned codigo_prioritario(input logic [MAX_TECLAS-1:0] vetor);
        int unsigned indice;
        indice = 0;
        for (int unsigned i = 0; i < MAX_TECLAS; i++) begin
            if (vetor[i]) indice = i;
        end
        return indice;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
module sincronizador_2ff #(
    parameter int unsigned LARGURA = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);

    logic [LARGURA-1:0] meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/codificador_teclado_sincrono.sv
// Debounced priority encoder for an N-key keypad with a read-pulse handshake.
// Optional auto-repeat while a key is held: define AUTO_REPEAT_EN.
module codificador_teclado_sincrono
    import codificador_teclado_pkg::*;
#(
    parameter int unsigned NUM_TECLAS     = 10,
    parameter int unsigned LARGURA_CODIGO = $clog2(NUM_TECLAS),
    parameter int unsigned CICLOS_FILTRO  = 16,
    parameter int unsigned ATRASO_REPETE  = 1000,
    parameter int unsigned PERIODO_REPETE = 200
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      enableN,
    input  logic [NUM_TECLAS-1:0]     tecladoNumerico,
    input  logic                      leitura,
    output logic [LARGURA_CODIGO-1:0] saidaCodigo,
    output logic                      dadoValido,
    output logic                      sobrescrita,
    output logic                      teclaAtiva
);

    if (NUM_TECLAS < 2 || NUM_TECLAS > MAX_TECLAS || CICLOS_FILTRO < 1
        || ATRASO_REPETE < 1 || PERIODO_REPETE < 1) begin : g_parametros_invalidos
        $error("codificador_teclado_sincrono: parameter out of range");
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned MAX_REPETE = (ATRASO_REPETE > PERIODO_REPETE) ?
                                         ATRASO_REPETE : PERIODO_REPETE;
    localparam int unsigned CONT_MAX   = (CICLOS_FILTRO > MAX_REPETE) ?
                                         CICLOS_FILTRO : MAX_REPETE;
`else
    localparam int unsigned CONT_MAX   = CICLOS_FILTRO;
`endif
    localparam int unsigned LARGURA_CONT = $clog2(CONT_MAX) + 1;
    localparam logic [LARGURA_CONT-1:0] FILTRO    = LARGURA_CONT'(CICLOS_FILTRO);
    localparam logic [LARGURA_CONT-1:0] CONT_UM   = LARGURA_CONT'(1);
    localparam logic [LARGURA_CONT-1:0] CONT_CHEIO = {LARGURA_CONT{1'b1}};

    logic [NUM_TECLAS-1:0]     teclas_sinc;
    logic [NUM_TECLAS-1:0]     vetor;
    logic [LARGURA_CODIGO-1:0] codigo;
    logic [LARGURA_CODIGO-1:0] candidato;
    logic [LARGURA_CONT-1:0]   cont;
    logic                      tem_tecla;
    logic                      captura_filtro;
    logic                      captura_repete;
    logic                      captura;
    estado_t                   estado;

    sincronizador_2ff #(
        .LARGURA(NUM_TECLAS)
    ) u_sincronizador (
        .clk_i (clock),
        .rst_ni(resetN),
        .d_i   (tecladoNumerico),
        .q_o   (teclas_sinc)
    );

    // enableN is a static mask, so it is applied after the synchroniser without delay.
    assign vetor     = teclas_sinc & {NUM_TECLAS{~enableN}};
    assign tem_tecla = |vetor;
    assign codigo    = LARGURA_CODIGO'(codigo_prioritario(MAX_TECLAS'(vetor)));

    assign captura_filtro = (estado == StFiltrando) && tem_tecla && (codigo == candidato)
                            && (cont == FILTRO);

`ifdef AUTO_REPEAT_EN
    localparam logic [LARGURA_CONT-1:0] ALVO_ATRASO  = LARGURA_CONT'(ATRASO_REPETE - 1);
    localparam logic [LARGURA_CONT-1:0] ALVO_PERIODO = LARGURA_CONT'(PERIODO_REPETE - 1);

    logic [LARGURA_CONT-1:0] cont_repete;
    logic                    ja_repetiu;

    assign captura_repete = (estado == StPressionado) && tem_tecla
                            && (cont_repete == (ja_repetiu ? ALVO_PERIODO : ALVO_ATRASO));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cont_repete <= '0;
            ja_repetiu  <= 1'b0;
        end else if ((estado == StPressionado) && tem_tecla) begin
            if (captura_repete) begin
                cont_repete <= '0;
                ja_repetiu  <= 1'b1;
            end else begin
                cont_repete <= cont_repete + 1'b1;
            end
        end else begin
            cont_repete <= '0;
            ja_repetiu  <= 1'b0;
        end
    end
`else
    assign captura_repete = 1'b0;
`endif

    assign captura = captura_filtro | captura_repete;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            estado     <= StOcioso;
            candidato  <= '0;
            cont       <= '0;
            teclaAtiva <= 1'b0;
        end else begin
            unique case (estado)
                StOcioso: begin
                    if (tem_tecla) begin
                        estado    <= StFiltrando;
                        candidato <= codigo;
                        cont      <= CONT_UM;
                    end
                end
                StFiltrando: begin
                    if (!tem_tecla) begin
                        estado <= StOcioso;
                    end else if (codigo != candidato) begin
                        candidato <= codigo;
                        cont      <= CONT_UM;
                    end else if (captura_filtro) begin
                        estado     <= StPressionado;
                        teclaAtiva <= 1'b1;
                    end else if (cont != CONT_CHEIO) begin
                        cont <= cont + 1'b1;
                    end
                end
                StPressionado: begin
                    if (!tem_tecla) begin
                        estado     <= StSoltando;
                        cont       <= CONT_UM;
                        teclaAtiva <= 1'b0;
                    end
                end
                StSoltando: begin
                    // Any key seen before the release is confirmed counts as bounce.
                    if (tem_tecla) begin
                        estado     <= StPressionado;
                        teclaAtiva <= 1'b1;
                    end else if (cont == FILTRO) begin
                        estado <= StOcioso;
                    end else if (cont != CONT_CHEIO) begin
                        cont <= cont + 1'b1;
                    end
                end
                default: begin
                    estado     <= StOcioso;
                    teclaAtiva <= 1'b0;
                end
            endcase
        end
    end

    // A capture beats a simultaneous read; an unread code lost to a capture sets the sticky flag.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            saidaCodigo <= '0;
            dadoValido  <= 1'b0;
            sobrescrita <= 1'b0;
        end else if (captura) begin
            saidaCodigo <= candidato;
            dadoValido  <= 1'b1;
            sobrescrita <= ~leitura & (dadoValido | sobrescrita);
        end else if (leitura && dadoValido) begin
            dadoValido  <= 1'b0;
            sobrescrita <= 1'b0;
        end
    end

endmodule

// File: tb/tb_codificador_teclado_sincrono.sv
// Bench for codificador_teclado_sincrono: directed scenarios plus random traffic vs. a run-length model.
module tb_codificador_teclado_sincrono;

    localparam int NT = 10;
    localparam int F  = 4;
    localparam int AR = 20;
    localparam int PR = 8;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          enableN = 1'b0;
    logic [NT-1:0] teclas = '0;
    logic          leitura = 1'b0;
    logic [3:0]    saidaCodigo;
    logic          dadoValido;
    logic          sobrescrita;
    logic          teclaAtiva;

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    codificador_teclado_sincrono #(
        .NUM_TECLAS    (NT),
        .CICLOS_FILTRO (F),
        .ATRASO_REPETE (AR),
        .PERIODO_REPETE(PR)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .enableN        (enableN),
        .tecladoNumerico(teclas),
        .leitura        (leitura),
        .saidaCodigo    (saidaCodigo),
        .dadoValido     (dadoValido),
        .sobrescrita    (sobrescrita),
        .teclaAtiva     (teclaAtiva)
    );

    // Reference model: pressed/released mode driven by run lengths of the sampled key code.
    logic [NT-1:0] hist[$];
    bit            m_pressed;
    int            m_run_code, m_run_len, m_zero_len, m_seg, m_borda, m_held;
    logic [3:0]    m_codigo;
    bit            m_dv, m_sob;

    task automatic modelo_reset();
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
        m_pressed = 0;
        m_run_len = 0;
        m_zero_len = 0;
        m_codigo = '0;
        m_dv = 0;
        m_sob = 0;
    endtask

    task automatic modelo_borda();
        logic [NT-1:0] vet;
        int            cod;
        bit            cap;
`ifdef AUTO_REPEAT_EN
        int            k;
`endif
        m_borda++;
        if (!resetN) begin
            modelo_reset();
        end else begin
            vet = enableN ? '0 : hist[0];
            void'(hist.pop_front());
            hist.push_back(teclas);
            cod = (vet != '0) ? $clog2(int'(vet) + 1) - 1 : 0;
            cap = 0;
            if (!m_pressed) begin
                if (vet != '0) begin
                    if (m_run_len > 0 && cod == m_run_code) m_run_len++;
                    else begin
                        m_run_code = cod;
                        m_run_len = 1;
                    end
                    if (m_run_len == F + 1) begin
                        cap = 1;
                        m_held = cod;
                        m_pressed = 1;
                        m_seg = m_borda;
                        m_zero_len = 0;
                    end
                end else begin
                    m_run_len = 0;
                end
            end else if (vet != '0) begin
                if (m_zero_len > 0) m_seg = m_borda;
                m_zero_len = 0;
`ifdef AUTO_REPEAT_EN
                k = m_borda - m_seg;
                if (k == AR || (k > AR && (k - AR) % PR == 0)) cap = 1;
`endif
            end else begin
                m_zero_len++;
                if (m_zero_len == F + 1) begin
                    m_pressed = 0;
                    m_run_len = 0;
                end
            end
            if (cap) begin
                m_sob = !leitura && (m_dv || m_sob);
                m_codigo = 4'(m_held);
                m_dv = 1;
            end else if (leitura && m_dv) begin
                m_dv = 0;
                m_sob = 0;
            end
        end
    endtask

    task automatic passo(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            modelo_borda();
            #1;
        end
    endtask

    task automatic ler();
        leitura = 1'b1;
        passo(1);
        leitura = 1'b0;
    endtask

    task automatic test_reset();
        passo(3);
        tests++;
        if ({saidaCodigo, dadoValido, sobrescrita, teclaAtiva} !== 7'd0) begin
            failed++;
            $display("FAIL reset_init: got %b expected 0000000",
                     {saidaCodigo, dadoValido, sobrescrita, teclaAtiva});
        end
        resetN = 1'b1;
        teclas = 10'(1 << 3);
        passo(4);
        resetN = 1'b0;
        teclas = '0;
        modelo_reset();
        #1;
        tests++;
        if ({saidaCodigo, dadoValido, sobrescrita, teclaAtiva} !== 7'd0) begin
            failed++;
            $display("FAIL reset_mid_filter: got %b expected 0000000",
                     {saidaCodigo, dadoValido, sobrescrita, teclaAtiva});
        end
        passo(2);
        resetN = 1'b1;
        passo(12);
        tests++;
        if (dadoValido !== 1'b0) begin
            failed++;
            $display("FAIL reset_no_capture: got %b expected 0", dadoValido);
        end
        teclas = 10'(1 << 8);
        passo(8);
        tests++;
        if (dadoValido !== 1'b1 || teclaAtiva !== 1'b1 || saidaCodigo !== 4'd8) begin
            failed++;
            $display("FAIL reset_pre_held: got dv=%b act=%b code=%0d expected dv=1 act=1 code=8",
                     dadoValido, teclaAtiva, saidaCodigo);
        end
        resetN = 1'b0;
        teclas = '0;
        modelo_reset();
        #1;
        tests++;
        if ({saidaCodigo, dadoValido, sobrescrita, teclaAtiva} !== 7'd0) begin
            failed++;
            $display("FAIL reset_held: got %b expected 0000000",
                     {saidaCodigo, dadoValido, sobrescrita, teclaAtiva});
        end
        passo(2);
        resetN = 1'b1;
        passo(4);
    endtask

    task automatic test_clean_press();
        teclas = 10'(1 << 7);
        for (int rel = 0; rel < 30; rel++) begin
            passo(1);
            if (rel == 5) begin
                tests++;
                if (dadoValido !== 1'b0) begin
                    failed++;
                    $display("FAIL clean_t5_dv: got %b expected 0", dadoValido);
                end
            end
            if (rel == 6) begin
                tests++;
                if (dadoValido !== 1'b1 || saidaCodigo !== 4'd7 || teclaAtiva !== 1'b1) begin
                    failed++;
                    $display("FAIL clean_t6: got dv=%b code=%0d act=%b expected dv=1 code=7 act=1",
                             dadoValido, saidaCodigo, teclaAtiva);
                end
            end
            tests++;
            if ({dadoValido, sobrescrita} !== {m_dv, m_sob}) begin
                failed++;
                $display("FAIL clean_hold rel=%0d: got dv/sob=%b%b expected %b%b",
                         rel, dadoValido, sobrescrita, m_dv, m_sob);
            end
        end
        teclas = '0;
        passo(10);
        tests++;
        if (teclaAtiva !== 1'b0 || saidaCodigo !== 4'd7) begin
            failed++;
            $display("FAIL clean_release: got act=%b code=%0d expected act=0 code=7",
                     teclaAtiva, saidaCodigo);
        end
        ler();
        tests++;
        if (dadoValido !== 1'b0 || sobrescrita !== 1'b0) begin
            failed++;
            $display("FAIL clean_read: got dv=%b sob=%b expected 0 0", dadoValido, sobrescrita);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            teclas = (i % 2 == 0) ? 10'(1 << 3) : '0;
            passo(2);
        end
        for (int rel = 2; rel < 8; rel++) begin
            passo(1);
            if (rel == 5) begin
                tests++;
                if (dadoValido !== 1'b0) begin
                    failed++;
                    $display("FAIL bounce_t5_dv: got %b expected 0", dadoValido);
                end
            end
        end
        tests++;
        if (dadoValido !== 1'b1 || saidaCodigo !== 4'd3 || sobrescrita !== 1'b0) begin
            failed++;
            $display("FAIL bounce_capture: got dv=%b code=%0d sob=%b expected dv=1 code=3 sob=0",
                     dadoValido, saidaCodigo, sobrescrita);
        end
        ler();
        passo(6);
        tests++;
        if (dadoValido !== 1'b0) begin
            failed++;
            $display("FAIL bounce_single: got dv=%b expected 0", dadoValido);
        end
        teclas = '0;
        passo(10);
    endtask

    task automatic test_priority();
        teclas = 10'((1 << 2) | (1 << 9));
        passo(8);
        tests++;
        if (dadoValido !== 1'b1 || saidaCodigo !== 4'd9) begin
            failed++;
            $display("FAIL prio_code: got dv=%b code=%0d expected dv=1 code=9",
                     dadoValido, saidaCodigo);
        end
        ler();
        teclas = 10'(1 << 2);
        passo(12);
        tests++;
        if (dadoValido !== 1'b0 || teclaAtiva !== 1'b1 || saidaCodigo !== 4'd9) begin
            failed++;
            $display("FAIL prio_no_recapture: got dv=%b act=%b code=%0d expected 0 1 9",
                     dadoValido, teclaAtiva, saidaCodigo);
        end
        teclas = '0;
        passo(10);
    endtask

    task automatic test_handshake();
        teclas = 10'(1 << 5);
        passo(8);
        tests++;
        if (dadoValido !== 1'b1 || saidaCodigo !== 4'd5) begin
            failed++;
            $display("FAIL hs_first: got dv=%b code=%0d expected dv=1 code=5",
                     dadoValido, saidaCodigo);
        end
        teclas = '0;
        passo(8);
        teclas = 10'(1 << 1);
        passo(8);
        tests++;
        if (dadoValido !== 1'b1 || saidaCodigo !== 4'd1 || sobrescrita !== 1'b1) begin
            failed++;
            $display("FAIL hs_overwrite: got dv=%b code=%0d sob=%b expected dv=1 code=1 sob=1",
                     dadoValido, saidaCodigo, sobrescrita);
        end
        ler();
        tests++;
        if (dadoValido !== 1'b0 || sobrescrita !== 1'b0 || saidaCodigo !== 4'd1) begin
            failed++;
            $display("FAIL hs_read: got dv=%b sob=%b code=%0d expected dv=0 sob=0 code=1",
                     dadoValido, sobrescrita, saidaCodigo);
        end
        teclas = '0;
        passo(10);
    endtask

    task automatic test_enable();
        enableN = 1'b1;
        teclas = 10'(1 << 4);
        passo(15);
        tests++;
        if (dadoValido !== 1'b0 || teclaAtiva !== 1'b0) begin
            failed++;
            $display("FAIL enable_masked: got dv=%b act=%b expected 0 0", dadoValido, teclaAtiva);
        end
        teclas = '0;
        passo(3);
        enableN = 1'b0;
        passo(8);
        teclas = 10'(1 << 4);
        passo(8);
        enableN = 1'b1;
        passo(8);
        tests++;
        if (teclaAtiva !== 1'b0 || dadoValido !== 1'b1 || saidaCodigo !== 4'd4) begin
            failed++;
            $display("FAIL enable_mid_press: got act=%b dv=%b code=%0d expected act=0 dv=1 code=4",
                     teclaAtiva, dadoValido, saidaCodigo);
        end
        teclas = '0;
        passo(4);
        enableN = 1'b0;
        passo(4);
        ler();
        tests++;
        if ({dadoValido, sobrescrita} !== {m_dv, m_sob}) begin
            failed++;
            $display("FAIL enable_after: got %b%b expected %b%b",
                     dadoValido, sobrescrita, m_dv, m_sob);
        end
    endtask

    task automatic test_auto_repeat();
        int esperado[$];
        int visto[$];
        bit anterior;
`ifdef AUTO_REPEAT_EN
        esperado = '{6, 26, 34, 42};
`else
        esperado = '{6};
`endif
        anterior = 0;
        teclas = 10'(1 << 6);
        for (int rel = 0; rel < 50; rel++) begin
            passo(1);
            leitura = 1'b0;
            if (dadoValido && !anterior) visto.push_back(rel);
            anterior = dadoValido;
            if (dadoValido) leitura = 1'b1;
        end
        leitura = 1'b0;
        tests++;
        if (visto.size() != esperado.size()) begin
            failed++;
            $display("FAIL repeat_count: got %0d captures expected %0d",
                     visto.size(), esperado.size());
        end else begin
            for (int i = 0; i < esperado.size(); i++) begin
                tests++;
                if (visto[i] != esperado[i]) begin
                    failed++;
                    $display("FAIL repeat_edge[%0d]: got %0d expected %0d",
                             i, visto[i], esperado[i]);
                end
            end
        end
        teclas = '0;
        passo(10);
        ler();
    endtask

    task automatic test_random();
        int dur;
        dur = 0;
        for (int c = 0; c < 600; c++) begin
            if (dur == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    teclas = '0;
                    2, 3:    teclas = 10'(1 << $urandom_range(0, NT - 1));
                    default: teclas = 10'($urandom);
                endcase
                enableN = ($urandom_range(0, 9) == 0);
                dur = $urandom_range(1, 12);
            end
            dur--;
            leitura = ($urandom_range(0, 7) == 0);
            passo(1);
            tests++;
            if ({saidaCodigo, dadoValido, sobrescrita, teclaAtiva}
                !== {m_codigo, m_dv, m_sob, (m_pressed && m_zero_len == 0)}) begin
                failed++;
                $display("FAIL random c=%0d: got code/dv/sob/act=%0d/%b/%b/%b expected %0d/%b/%b/%b",
                         c, saidaCodigo, dadoValido, sobrescrita, teclaAtiva,
                         m_codigo, m_dv, m_sob, (m_pressed && m_zero_len == 0));
            end
        end
        leitura = 1'b0;
        enableN = 1'b0;
        teclas = '0;
    endtask

    initial begin
        modelo_reset();
        m_borda = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_handshake();
        test_enable();
        test_auto_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
